inst_fetch_queue: RTL and testbench

- Instruction fetch front end sitting directly upstream of the single-cycle core's decoder.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions, each with its PC, in a small FIFO and presents them to the core with a valid/ready handshake.
- Supports redirects (branch, jump, jr) that flush the queue and restart fetch at a new PC.

---
 rtl/inst_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding imem request
// at a time and buffers returned words with their PCs in a DEPTH-entry FIFO.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  output logic                   imem_req,
  output logic [63:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_data,
  output logic [31:0]            inst,
  output logic [63:0]            inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state;
  logic          req_q;
  logic [63:0]   fetch_pc;
  logic [63:0]   req_addr;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   inst_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];

  logic          pop;
  logic          push;
  logic          pop_eff;
  logic [63:0]   new_pc;
  logic [63:0]   next_addr;
  logic [CW-1:0] count_after;
  logic          room_after;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign new_pc      = {redirect_pc[63:2], 2'b00};
  assign next_addr   = req_addr + 64'd4;
  assign pop         = inst_valid & inst_ready;
  assign push        = (state == REQ) & imem_ack & ~redirect;
  assign pop_eff     = pop & ~redirect;
  assign count_after = count + CW'(push) - CW'(pop_eff);
  assign room_after  = count_after < FULL;

  // A request is only launched while the FIFO has room, and kept streaming only
  // if the entry it returns will still fit, so a push never finds the FIFO full.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            state    <= REQ;
            req_q    <= 1'b1;
            fetch_pc <= new_pc;
            req_addr <= new_pc;
          end else if (count < FULL) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              fetch_pc <= new_pc;
              req_addr <= new_pc;
            end else begin
              fetch_pc <= next_addr;
              if (room_after) begin
                req_addr <= next_addr;
              end else begin
                state <= IDLE;
                req_q <= 1'b0;
              end
            end
          end else if (redirect) begin
            // address must stay put until the memory acks the stale request
            fetch_pc <= new_pc;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (redirect) fetch_pc <= new_pc;
          if (imem_ack) begin
            state    <= REQ;
            req_addr <= redirect ? new_pc : fetch_pc;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; a redirect flushes and cancels any same-cycle push or pop
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= imem_data;
        pc_mem[wr_ptr]   <= req_addr;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = req_addr;
  assign inst_valid = count != '0;
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign fill_level = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue: a program-order fetch model
// predicts every delivered {pc, inst}; a separate monitor compares the FIFO head.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [$clog2(DEPTH):0] fill_level;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fill_level(fill_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          pushes = 0;
  int          pops = 0;
  bit          outstanding = 1'b0;
  bit          stale = 1'b0;
  logic [63:0] out_addr = '0;
  logic [63:0] exp_next = RESET_PC;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Program-order model: every accepted word belongs to the address that follows
  // the last accepted one, or to the latest redirect target; stale acks are dropped.
  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      exp_q.delete();
      outstanding = 1'b0;
      stale       = 1'b0;
      exp_next    = RESET_PC;
    end else begin
      if (imem_req) begin
        if (!outstanding) begin
          chk(imem_addr == exp_next, "req_addr", imem_addr, exp_next);
          outstanding = 1'b1;
          out_addr    = imem_addr;
          stale       = 1'b0;
        end else begin
          chk(imem_addr == out_addr, "addr_stable", imem_addr, out_addr);
        end
        if (imem_ack) begin
          outstanding = 1'b0;
          if (!stale && !redirect) begin
            chk(exp_q.size() < DEPTH, "no_overflow", 64'(exp_q.size()), 64'(DEPTH - 1));
            exp_q.push_back('{pc: out_addr, data: imem_data});
            exp_next = out_addr + 64'd4;
            pushes++;
          end
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_next = {redirect_pc[63:2], 2'b00};
        if (outstanding) stale = 1'b1;
      end
    end
  end

  // Monitor: compares the presented head entry and retires it on a real pop
  always begin
    @(negedge clock);
    if (!reset) begin
      chk(inst_valid == (exp_q.size() != 0), "inst_valid", 64'(inst_valid),
          64'(exp_q.size() != 0));
      chk(fill_level == exp_q.size(), "fill_level", 64'(fill_level), 64'(exp_q.size()));
      if (fill_level == DEPTH) chk(!imem_req, "idle_when_full", 64'(imem_req), 64'd0);
      if (inst_valid && exp_q.size() != 0) begin
        chk(inst == exp_q[0].data, "inst", 64'(inst), 64'(exp_q[0].data));
        chk(inst_pc == exp_q[0].pc, "inst_pc", inst_pc, exp_q[0].pc);
        if (inst_ready && !redirect) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  function automatic logic [63:0] pick_pc();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      1: r = 64'h400 | 64'($urandom_range(0, 3));
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input int ack_pct, input int rdy_pct, input int redir_pct);
    imem_ack    = imem_req && ($urandom_range(0, 99) < ack_pct);
    imem_data   = $urandom;
    inst_ready  = $urandom_range(0, 99) < rdy_pct;
    redirect    = $urandom_range(0, 99) < redir_pct;
    redirect_pc = pick_pc();
  endtask

  task automatic cycles(input int n, input int ack_pct, input int rdy_pct,
                        input int redir_pct);
    repeat (n) begin
      @(posedge clock);
      #1;
      drive(ack_pct, rdy_pct, redir_pct);
    end
  endtask

  task automatic check_reset_outputs();
    chk(imem_req == 1'b0, "rst_imem_req", 64'(imem_req), 64'd0);
    chk(imem_addr == RESET_PC, "rst_imem_addr", imem_addr, RESET_PC);
    chk(inst_valid == 1'b0, "rst_inst_valid", 64'(inst_valid), 64'd0);
    chk(inst == 32'd0, "rst_inst", 64'(inst), 64'd0);
    chk(inst_pc == 64'd0, "rst_inst_pc", inst_pc, 64'd0);
    chk(fill_level == '0, "rst_fill_level", 64'(fill_level), 64'd0);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    drive(100, 100, 0);
    @(posedge clock);
    #1;
    chk(imem_req == 1'b1, "first_req", 64'(imem_req), 64'd1);
    chk(imem_addr == RESET_PC, "first_addr", imem_addr, RESET_PC);
    drive(100, 100, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    check_reset_outputs();
    release_reset();
    // streaming with a 0-wait memory, wrapping through the top of the address space
    cycles(40, 100, 100, 0);
    // back-pressure fills the FIFO, then a single pop reopens one slot
    cycles(12, 100, 0, 0);
    cycles(1, 100, 100, 0);
    cycles(6, 100, 0, 0);
    cycles(20, 100, 100, 0);
    cycles(400, 40, 70, 8);
    // reset in the middle of an outstanding request
    for (int i = 0; i < 20 && !imem_req; i++) cycles(1, 0, 50, 0);
    chk(imem_req == 1'b1, "midreq_setup", 64'(imem_req), 64'd1);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    redirect = 1'b0;
    imem_ack = 1'b0;
    @(posedge clock);
    #2;
    check_reset_outputs();
    release_reset();
    cycles(400, 60, 60, 5);
    cycles(100, 100, 100, 3);
    cycles(60, 30, 20, 10);
    chk(pushes > 200, "progress_pushes", 64'(pushes), 64'd201);
    chk(pops > 150, "progress_pops", 64'(pops), 64'd151);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
